// File: rtl/fifo_read_scheduler_if.sv
// Handshake bundle between the read scheduler, the FIFO read side and the consumers.
// master: scheduler side; slave: FIFO/consumer environment side.
interface fifo_read_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4
);
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_empty;
  logic                  fifo_read_en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_REQ-1:0]    out_valid;
  logic                  busy;

  modport master (
    input  fifo_read_data, fifo_empty, req,
    output fifo_read_en, grant, out_data, out_valid, busy
  );

  modport slave (
    output fifo_read_data, fifo_empty, req,
    input  fifo_read_en, grant, out_data, out_valid, busy
  );
endinterface

// File: rtl/fifo_read_scheduler.sv
// Round-robin burst scheduler sharing one FIFO read port among NUM_REQ consumers.
// Optional FIFO_SCHED_PRIORITY_EN: requester 0 gets fixed priority, 1..NUM_REQ-1 rotate.
module fifo_read_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  read_clk,
  input  logic                  areset,
  fifo_read_scheduler_if.master bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      ptr_nxt;
  logic                  pop;
  logic                  last_pop;

  // Pick the first requester at or after the rotation pointer.
  always_comb begin
    int unsigned idx;
`ifdef FIFO_SCHED_PRIORITY_EN
    int unsigned base;
`endif
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
`ifdef FIFO_SCHED_PRIORITY_EN
    base = (ptr_q == '0) ? 0 : 32'(ptr_q) - 1;
    if (bus.req[0]) begin
      sel_found = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
        idx = 1 + ((base + i) % (NUM_REQ - 1));
        if (!sel_found && bus.req[IDX_W'(idx)]) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(idx);
        end
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!sel_found && bus.req[IDX_W'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(idx);
      end
    end
`endif
  end

  // Pointer after a burst; in priority mode requester 0 never disturbs the rotation.
  always_comb begin
`ifdef FIFO_SCHED_PRIORITY_EN
    if (gidx_q == '0) begin
      ptr_nxt = ptr_q;
    end else if (gidx_q == IDX_W'(NUM_REQ - 1)) begin
      ptr_nxt = IDX_W'(1);
    end else begin
      ptr_nxt = gidx_q + IDX_W'(1);
    end
`else
    if (gidx_q == IDX_W'(NUM_REQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = gidx_q + IDX_W'(1);
    end
`endif
  end

  assign pop      = (state_q == ST_GRANT) && bus.req[gidx_q] && !bus.fifo_empty &&
                    (cnt_q < CNT_W'(BURST_LEN));
  assign last_pop = pop && (cnt_q == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    out_data_d  = out_data_q;
    out_valid_d = '0;

    if (pop) begin
      out_data_d  = bus.fifo_read_data;
      out_valid_d = grant_q;
      cnt_d       = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_found && !bus.fifo_empty) begin
          state_d = ST_GRANT;
          grant_d = NUM_REQ'(1) << sel_idx;
          gidx_d  = sel_idx;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        // A final pop and a req drop on the same edge still deliver the word.
        if (last_pop || !bus.req[gidx_q] || bus.fifo_empty) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge read_clk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.fifo_read_en = pop;
  assign bus.grant        = grant_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Scoreboard bench for fifo_read_scheduler: FIFO model, expected-delivery queue, grant/burst log.
module tb_fifo_read_scheduler;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned BL = 4;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  fifo_read_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_read_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .read_clk (clk),
    .areset   (areset),
    .bus      (bus)
  );

  // FIFO model: fall-through head, popped on read_en edges
  logic [7:0] mem [256];
  logic [7:0] rd_ptr;
  logic [7:0] wr_ptr;
  assign bus.fifo_read_data = mem[rd_ptr];
  assign bus.fifo_empty     = (rd_ptr == wr_ptr);
  always @(posedge clk or posedge areset) begin
    if (areset) rd_ptr <= 8'd0;
    else if (bus.fifo_read_en) rd_ptr <= rd_ptr + 8'd1;
  end

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;
  int burst_words = 0;
  logic [11:0] exp_q [$];
  logic [3:0]  grant_log [$];
  int          burst_log [$];
  logic [3:0]  prev_grant = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each strobe, logs grant owners and burst sizes
  always @(negedge clk) begin
    logic [11:0] e;
    if (!areset) begin
      checks++;
      if (bus.fifo_read_en && (bus.fifo_empty || bus.grant == 4'd0)) begin
        failures++;
        $display("FAIL read_en_guard actual=1 required=0 empty=%0b grant=%0h",
                 bus.fifo_empty, bus.grant);
      end
      if (bus.out_valid != 4'd0) begin
        delivered++;
        burst_words++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery actual=%0h/%0h required=none",
                   bus.out_valid, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("delivery", 32'({bus.out_valid, bus.out_data}), 32'(e));
        end
      end
      if (bus.grant != prev_grant) begin
        if (prev_grant != 4'd0) burst_log.push_back(burst_words);
        if (bus.grant != 4'd0) begin
          grant_log.push_back(bus.grant);
          burst_words = 0;
        end
      end
    end
    prev_grant = bus.grant;
  end

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_word(input logic [3:0] owner, input logic [7:0] w);
    exp_q.push_back({owner, w});
  endtask

  task automatic clear_logs();
    delivered = 0;
    exp_q.delete();
    grant_log.delete();
    burst_log.delete();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    bus.req = 4'd0;
    wr_ptr = 8'd0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    clear_logs();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_deliv(input int n);
    int i = 0;
    while (delivered < n && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("delivered_count", 32'(delivered), 32'(n));
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || bus.busy) && i < 400) begin
      @(negedge clk);
      #1;
      i++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  // Expected sequences packed one nibble per entry, entry 0 in the low nibble
  task automatic chk_logs(input string name, input int n, input logic [31:0] gseq,
                          input logic [31:0] bseq);
    chk({name, "_grant_count"}, 32'(grant_log.size()), 32'(n));
    chk({name, "_burst_count"}, 32'(burst_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < grant_log.size()) chk({name, "_grant_order"}, 32'(grant_log[i]), 32'(gseq[4*i +: 4]));
      if (i < burst_log.size()) chk({name, "_burst_len"}, 32'(burst_log[i]), 32'(bseq[4*i +: 4]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    bus.req = 4'd0;
    wr_ptr = 8'd0;
    do_reset();

    // Reset state
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_read_en", 32'(bus.fifo_read_en), 32'd0);

    // Async reset mid-burst of requester 1
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    expect_word(4'b0010, 8'hA0);
    expect_word(4'b0010, 8'hA1);
    bus.req = 4'b0010;
    wait_deliv(2);
    chk("midburst_grant", 32'(bus.grant), 32'b0010);
    #2 areset = 1'b1;
    #1;
    chk("async_grant", 32'(bus.grant), 32'd0);
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'd0;
    wr_ptr = 8'd0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    clear_logs();
    push(8'hB0);
    expect_word(4'b0001, 8'hB0);
    bus.req = 4'b0011;
    wait_done("post_reset");
    chk_logs("post_reset", 1, 32'h1, 32'h1);

    // Single requester, 10 words: bursts 4,4,2
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      push(8'(i));
      expect_word(4'b0001, 8'(i));
    end
    bus.req = 4'b0001;
    wait_done("single");
    chk_logs("single", 3, 32'h111, 32'h244);

    // All four requesting, deep FIFO: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h10 + i));
      expect_word(4'(4'b0001 << ((i / 4) % 4)), 8'(8'h10 + i));
    end
    bus.req = 4'b1111;
    wait_done("all_req");
    chk_logs("all_req", 5, 32'h18421, 32'h44444);

    // Requester 2 drops after 2 pops; requester 3 next, then 0
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    expect_word(4'b0100, 8'hC0);
    expect_word(4'b0100, 8'hC1);
    for (int i = 2; i < 6; i++) expect_word(4'b1000, 8'(8'hC0 + i));
    expect_word(4'b0001, 8'hC6);
    expect_word(4'b0001, 8'hC7);
    bus.req = 4'b0100;
    wait_deliv(2);
    bus.req = 4'b1001;
    wait_done("req_drop");
    chk_logs("req_drop", 3, 32'h184, 32'h242);

    // FIFO runs empty mid-burst, then refills
    do_reset();
    push(8'hD0);
    push(8'hD1);
    for (int i = 0; i < 5; i++) expect_word(4'b0001, 8'(8'hD0 + i));
    bus.req = 4'b0001;
    wait_deliv(2);
    repeat (5) @(negedge clk);
    #1;
    chk("empty_busy", 32'(bus.busy), 32'd0);
    chk("empty_grant", 32'(bus.grant), 32'd0);
    chk("empty_read_en", 32'(bus.fifo_read_en), 32'd0);
    for (int i = 2; i < 5; i++) push(8'(8'hD0 + i));
    wait_done("empty_mid");
    chk_logs("empty_mid", 2, 32'h11, 32'h32);

`ifdef FIFO_SCHED_PRIORITY_EN
    // Requester 0 raised during requester 1's burst: served before requester 2
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push(8'(8'hE0 + i));
      expect_word((i < 4) ? 4'b0010 : (i < 8) ? 4'b0001 : 4'b0100, 8'(8'hE0 + i));
    end
    bus.req = 4'b1110;
    wait_deliv(1);
    bus.req = 4'b1111;
    wait_deliv(8);
    bus.req = 4'b1110;
    wait_done("priority");
    chk_logs("priority", 3, 32'h412, 32'h444);
`endif

    bus.req = 4'd0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_read_scheduler.md
# fifo_read_scheduler

Read-side scheduler for the dual-clock FIFO: shares the single FIFO read port among NUM_REQ consumers in the read_clk domain. It grants the port round-robin in bounded bursts and pops words from the FIFO's fall-through output. Each popped word is delivered to the granted consumer as a registered word with a one-hot valid strobe. It sits between the FIFO's read side (read_data/read_en/empty) and the consumers (UART TX, debug port, etc.).

## Interface

- DATA_WIDTH, 8, FIFO word width.
- NUM_REQ, 4, number of requesters, 2..8.
- BURST_LEN, 4, maximum words popped per grant, 1..255.
- read_clk  in  1  read-domain clock; all state updates on posedge.
- areset  in  1  asynchronous, active-high reset.
- fifo_read_data  in  DATA_WIDTH  FIFO head word (combinational, valid while fifo_empty=0).
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  pop strobe to FIFO (combinational).
- req  in  NUM_REQ  level request per consumer.
- grant  out  NUM_REQ  one-hot current owner, registered; 0 when idle.
- out_data  out  DATA_WIDTH  last popped word, registered.
- out_valid  out  NUM_REQ  one-hot, one-cycle strobe: out_data belongs to that consumer.
- busy  out  1  high in GRANT state.

## Operation

- Reset values: grant=0, out_data=0, out_valid=0, busy=0, state=IDLE, burst count=0, round-robin pointer=0 (requester 0 checked first).
- FSM states: IDLE, GRANT.
- IDLE: if (req != 0) and fifo_empty=0, select the first requester with req set, searching from pointer upward with wrap; load grant, clear count, go to GRANT. Otherwise stay.
- GRANT: fifo_read_en = req[g] & ~fifo_empty & (count < BURST_LEN). On a pop edge: out_data <= fifo_read_data, out_valid <= grant, count++.
- Exit GRANT -> IDLE on the edge where any holds: pop makes count = BURST_LEN; req[g]=0; fifo_empty=1. On exit: grant <= 0, pointer <= g+1 mod NUM_REQ.
- fifo_read_en is never asserted in IDLE or while fifo_empty=1, so no pop is ever issued against an empty FIFO.
- out_valid deasserts on every edge without a pop.
- count width = ceil(log2(BURST_LEN+1)), no wrap possible.
- areset mid-burst: all registers clear immediately. The word in flight is dropped from the output. The FIFO index is handled by the FIFO's own reset.

## Timing

- Arbitration: req seen in IDLE at edge N -> grant valid after N. First pop at edge N+1; out_valid high during cycle after N+1.
- Pop-to-delivery latency: 1 cycle.
- Sustained throughput: 1 word/cycle within a burst. Plus one IDLE cycle between bursts, so BURST_LEN/(BURST_LEN+1) max.
- req deassert at edge M while granted: no pop at M; grant clears after M.
- Simultaneous last-burst-pop and req drop: pop happens, then exit.

## Configuration

- FIFO_SCHED_PRIORITY_EN defined: requester 0 has fixed highest priority in IDLE. Requesters 1..NUM_REQ-1 share round-robin among themselves, and the pointer never selects 0 by rotation. Bursts in progress are not preempted.
- Undefined: pure round-robin over all NUM_REQ requesters as above.

## Test plan

- Reset: assert areset mid-burst with grant=0b0010 -> grant, out_valid, busy go 0 without a clock edge; after release, the first grant goes to requester 0.
- Single requester, FIFO holding 10 words 0x01..0x0A, BURST_LEN=4 -> bursts of 4,4,2 with one idle cycle between. out_valid=0b0001 with data 0x01..0x0A in order; exit on empty after 0x0A.
- All four requesting, FIFO deep -> grant order 0,1,2,3,0. Each burst is exactly 4 words; no word is duplicated or skipped across owners.
- Requester 2 drops req after 2 pops -> exactly 2 out_valid=0b0100 strobes; next grant goes to requester 3.
- FIFO goes empty mid-burst -> fifo_read_en stays 0 while empty; return to IDLE; resume on the next non-empty.
- FIFO_SCHED_PRIORITY_EN defined, req=0b1110 continuous, req[0] raised during requester 1's burst -> burst completes, then requester 0 is granted before requester 2.
